// File: rtl/conv_encoder_tx_pkg.sv
// Shared definitions for the rate-1/2 convolutional link: default code
// parameters, the transmit FSM state type and the reference symbol function
// used by both ends of the link.
package conv_encoder_tx_pkg;

    localparam int              CONV_DATA_W = 8;
    localparam int              CONV_K      = 3;
    localparam logic [CONV_K-1:0] CONV_G0   = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1   = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } conv_state_t;

    // Symbol for input bit u with encoder memory sreg = {s1 .. s(K-1)},
    // s1 being the most recent bit. Result is {G0 parity, G1 parity}.
    function automatic logic [1:0] conv_sym(input logic u,
                                            input logic [CONV_K-2:0] sreg);
        logic [CONV_K-1:0] r;
        r = {u, sreg};
        return {^(r & CONV_G0), ^(r & CONV_G1)};
    endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Byte-in / symbol-out bundle of the convolutional transmitter.
// master: the side that supplies payload words and consumes symbols.
// slave : the encoder itself.
interface conv_encoder_tx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data_i;
    logic              data_valid_i;
    logic              last_i;
    logic              data_ready_o;
    logic [1:0]        sym_o;
    logic              sym_valid_o;
    logic              frame_done_o;
    logic [15:0]       err_cnt_o;

    modport master (
        output data_i, data_valid_i, last_i,
        input  data_ready_o, sym_o, sym_valid_o, frame_done_o, err_cnt_o
    );

    modport slave (
        input  data_i, data_valid_i, last_i,
        output data_ready_o, sym_o, sym_valid_o, frame_done_o, err_cnt_o
    );

endinterface

// File: rtl/conv_encoder_tx_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) that advances one
// step per enabled cycle. Only built when CONV_TX_ERR_INJ_EN is defined,
// where it paces the deliberate symbol corruption of the transmitter.
`ifdef CONV_TX_ERR_INJ_EN
module conv_encoder_tx_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    // Advance the sequence on each step request; reseed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign state_o = lfsr_q;

endmodule
`endif

// File: rtl/conv_encoder_tx.sv
// Transmit side of the rate-1/2 convolutional link. Accepts payload words over
// valid/ready, serializes them MSB first and emits one 2-bit encoded symbol per
// clock, appending K-1 zero tail bits after the last word of a frame so the
// decoder trellis terminates in state 0.
// Optional feature: define CONV_TX_ERR_INJ_EN to corrupt sym_o[0] at a rate of
// 1/2**ERR_RATE_LOG2 (LFSR paced) and count the injected errors on err_cnt_o.
module conv_encoder_tx
    import conv_encoder_tx_pkg::*;
#(
    parameter int             DATA_W        = CONV_DATA_W,
    parameter int             K             = CONV_K,
    parameter logic [K-1:0]   G0            = CONV_G0,
    parameter logic [K-1:0]   G1            = CONV_G1,
    parameter int             ERR_RATE_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    conv_encoder_tx_if.slave  bus
);

    localparam int             CNT_W    = $clog2((DATA_W > K) ? DATA_W : K);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TAIL_END = CNT_W'(K - 2);

    if (ERR_RATE_LOG2 < 0 || ERR_RATE_LOG2 > 16) begin : g_rate_chk
        $error("ERR_RATE_LOG2 must lie in 0..16");
    end

    function automatic logic [1:0] sym_of(input logic ub, input logic [K-2:0] s);
        logic [K-1:0] r;
        r = {ub, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    conv_state_t       state_p0, state_n;
    logic [CNT_W-1:0]  cnt_p0, cnt_n;
    logic              last_p0, last_n;
    logic [DATA_W-1:0] data_p0;
    logic [K-2:0]      sreg_p0;

    logic              hs;
    logic              emit;
    logic              u;
    logic [1:0]        sym_n;
    logic              rdy_n;
    logic              done_n;
    logic              inj;

    logic              rdy_p1;
    logic              vld_p1;
    logic              done_p1;
    logic [1:0]        sym_p1;
    logic [15:0]       err_p1;

    assign hs = bus.data_valid_i & rdy_p1;

    // ---- stage p0: frame control and encoder memory ----
    // State, bit/tail counter, latched last flag and encoder shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            last_p0  <= 1'b0;
            sreg_p0  <= '0;
        end else begin
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
            last_p0  <= last_n;
            if (emit) begin
                sreg_p0 <= (K-1)'({u, sreg_p0} >> 1);
            end
        end
    end

    // Payload shifter: holds the not-yet-encoded bits of the current word.
    always_ff @(posedge clk) begin
        if (hs) begin
            data_p0 <= {bus.data_i[DATA_W-2:0], 1'b0};
        end else if (state_p0 == SHIFT) begin
            data_p0 <= {data_p0[DATA_W-2:0], 1'b0};
        end
    end

    // Next-state decode: word sequencing, back-to-back chaining and tail.
    always_comb begin
        state_n = state_p0;
        cnt_n   = cnt_p0;
        last_n  = last_p0;
        case (state_p0)
            IDLE: begin
                if (hs) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    last_n  = bus.last_i;
                end
            end
            SHIFT: begin
                if (cnt_p0 == LAST_BIT) begin
                    cnt_n = '0;
                    if (hs) begin
                        state_n = SHIFT;
                        last_n  = bus.last_i;
                    end else if (last_p0) begin
                        state_n = TAIL;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_p0 + CNT_W'(1);
                end
            end
            TAIL: begin
                if (cnt_p0 == TAIL_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    last_n  = 1'b0;
                end else begin
                    cnt_n = cnt_p0 + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                last_n  = 1'b0;
            end
        endcase
    end

    // Output decode: the bit encoded at this edge and the next-cycle flags.
    always_comb begin
        emit   = (state_n != IDLE);
        u      = 1'b0;
        if (hs) begin
            u = bus.data_i[DATA_W-1];
        end else if (state_n == SHIFT) begin
            u = data_p0[DATA_W-1];
        end
        sym_n  = sym_of(u, sreg_p0);
        rdy_n  = (state_n == IDLE) ||
                 ((state_n == SHIFT) && (cnt_n == LAST_BIT) && !last_n);
        done_n = (state_n == TAIL) && (cnt_n == TAIL_END);
    end

`ifdef CONV_TX_ERR_INJ_EN
    localparam logic [15:0] INJ_MASK = 16'((32'd1 << ERR_RATE_LOG2) - 32'd1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] lfsr;

    conv_encoder_tx_lfsr16 #(.SEED(16'hACE1)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_i  (emit),
        .state_o (lfsr)
    );

    assign inj = emit && ((lfsr & INJ_MASK) == 16'd0);

    // Saturating count of corrupted symbols.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_p1 <= '0;
        end else if (inj) begin
            err_p1 <= sat_inc16(err_p1);
        end
    end
`else
    assign inj    = 1'b0;
    assign err_p1 = '0;
`endif

    // ---- stage p1: registered symbol stream and handshake ----
    // Registered outputs; symbol forced to 0 when nothing is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            sym_p1  <= 2'b00;
        end else begin
            rdy_p1  <= rdy_n;
            vld_p1  <= emit;
            done_p1 <= done_n;
            sym_p1  <= emit ? (sym_n ^ {1'b0, inj}) : 2'b00;
        end
    end

    assign bus.data_ready_o = rdy_p1;
    assign bus.sym_valid_o  = vld_p1;
    assign bus.frame_done_o = done_p1;
    assign bus.sym_o        = sym_p1;
    assign bus.err_cnt_o    = err_p1;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Bench for conv_encoder_tx: directed frames plus random frames, each symbol
// compared against a bit-history model of the rate-1/2 K=3 code.
module tb_conv_encoder_tx;

    localparam int DATA_W = 8;
    localparam int K      = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_encoder_tx_if #(.DATA_W(DATA_W)) bus ();

    conv_encoder_tx #(
        .DATA_W        (DATA_W),
        .K             (K),
        .G0            (3'b111),
        .G1            (3'b101),
        .ERR_RATE_LOG2 (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0] gen0 = 3'b111;
    logic [2:0] gen1 = 3'b101;

    bit         hist[$];
    logic [1:0] exp_sym[$];
    logic       exp_done[$];
    int         sym_since_rst = 0;

    logic [1:0] obs_sym[$];
    logic       obs_done[$];
    int         obs_stamp[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.sym_valid_o === 1'b1) begin
            obs_sym.push_back(bus.sym_o);
            obs_done.push_back(bus.frame_done_o);
            obs_stamp.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: symbol = parities of the last K input bits under each generator.
    function automatic void model_bit(input bit b, input bit done);
        logic [1:0] s;
        int n;
        hist.push_back(b);
        n = hist.size();
        s = 2'b00;
        for (int j = 0; j < K; j++) begin
            if (n - 1 - j >= 0) begin
                s[1] = s[1] ^ (gen0[K-1-j] & hist[n-1-j]);
                s[0] = s[0] ^ (gen1[K-1-j] & hist[n-1-j]);
            end
        end
`ifdef CONV_TX_ERR_INJ_EN
        s[0] = ~s[0];
`endif
        exp_sym.push_back(s);
        exp_done.push_back(done);
        sym_since_rst++;
    endfunction

    function automatic void model_word(input logic [7:0] w, input bit last);
        for (int i = DATA_W - 1; i >= 0; i--) model_bit(w[i], 1'b0);
        if (last) begin
            for (int t = 0; t < K - 1; t++) model_bit(1'b0, t == K - 2);
        end
    endfunction

    function automatic int exp_err();
`ifdef CONV_TX_ERR_INJ_EN
        return sym_since_rst;
`else
        return 0;
`endif
    endfunction

    task automatic send_word(input logic [7:0] w, input bit last);
        int n;
        @(negedge clk);
        bus.data_i       = w;
        bus.last_i       = last;
        bus.data_valid_i = 1'b1;
        n = 0;
        while (bus.data_ready_o !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (n < 64) else begin
            bad++;
            $error("FAIL handshake obs_ready=%b exp_ready=1", bus.data_ready_o);
        end
        if (n < 64) model_word(w, last);
        @(posedge clk);
        #1 bus.data_valid_i = 1'b0;
    endtask

    task automatic check_stream(input string tag, input bit contig);
        int n;
        int m;
        n = 0;
        while (obs_sym.size() < exp_sym.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        total++;
        assert (obs_sym.size() === exp_sym.size()) else begin
            bad++;
            $error("FAIL %s_count obs=%0d exp=%0d", tag, obs_sym.size(), exp_sym.size());
        end
        m = (obs_sym.size() < exp_sym.size()) ? obs_sym.size() : exp_sym.size();
        for (int i = 0; i < m; i++) begin
            total++;
            assert (obs_sym[i] === exp_sym[i]) else begin
                bad++;
                $error("FAIL %s_sym[%0d] obs=%b exp=%b", tag, i, obs_sym[i], exp_sym[i]);
            end
            total++;
            assert (obs_done[i] === exp_done[i]) else begin
                bad++;
                $error("FAIL %s_done[%0d] obs=%b exp=%b", tag, i, obs_done[i], exp_done[i]);
            end
            if (contig && i > 0) begin
                total++;
                assert (obs_stamp[i] - obs_stamp[i-1] === 1) else begin
                    bad++;
                    $error("FAIL %s_gap[%0d] obs=%0d exp=1", tag, i, obs_stamp[i] - obs_stamp[i-1]);
                end
            end
        end
        total++;
        assert (bus.data_ready_o === 1'b1) else begin
            bad++;
            $error("FAIL %s_idle_ready obs=%b exp=1", tag, bus.data_ready_o);
        end
        total++;
        assert (bus.err_cnt_o === 16'(exp_err())) else begin
            bad++;
            $error("FAIL %s_err_cnt obs=%0d exp=%0d", tag, bus.err_cnt_o, exp_err());
        end
        obs_sym.delete();
        obs_done.delete();
        obs_stamp.delete();
        exp_sym.delete();
        exp_done.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        assert (bus.sym_valid_o === 1'b0) else begin
            bad++; $error("FAIL %s_sym_valid obs=%b exp=0", tag, bus.sym_valid_o);
        end
        total++;
        assert (bus.sym_o === 2'b00) else begin
            bad++; $error("FAIL %s_sym obs=%b exp=00", tag, bus.sym_o);
        end
        total++;
        assert (bus.frame_done_o === 1'b0) else begin
            bad++; $error("FAIL %s_done obs=%b exp=0", tag, bus.frame_done_o);
        end
        total++;
        assert (bus.data_ready_o === 1'b0) else begin
            bad++; $error("FAIL %s_ready obs=%b exp=0", tag, bus.data_ready_o);
        end
        total++;
        assert (bus.err_cnt_o === 16'd0) else begin
            bad++; $error("FAIL %s_err_cnt obs=%0d exp=0", tag, bus.err_cnt_o);
        end
    endtask

    initial begin
        int nw;
        logic [7:0] w;

        rst              = 1'b1;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        bus.last_i       = 1'b0;

        // reset state, then ready on the first cycle after release
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        total++;
        assert (bus.data_ready_o === 1'b1) else begin
            bad++; $error("FAIL ready_after_reset obs=%b exp=1", bus.data_ready_o);
        end

        // single-word frames
        send_word(8'hA5, 1'b1);
        check_stream("a5_frame", 1'b1);
        send_word(8'h00, 1'b1);
        check_stream("zero_frame", 1'b1);

        // back-to-back words give an 18-symbol gap-free stream
        send_word(8'hFF, 1'b0);
        send_word(8'h00, 1'b1);
        check_stream("b2b_frame", 1'b1);

        // valid held while ready is low: word waits for the ready cycle
        send_word(8'h3C, 1'b0);
        bus.data_i       = 8'hC3;
        bus.last_i       = 1'b1;
        bus.data_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            assert (bus.data_ready_o === 1'b0) else begin
                bad++; $error("FAIL held_valid_ready obs=%b exp=0", bus.data_ready_o);
            end
        end
        send_word(8'hC3, 1'b1);
        check_stream("held_valid", 1'b1);

        // reset on the 4th symbol, then the same frame from scratch
        send_word(8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        hist.delete();
        exp_sym.delete();
        exp_done.delete();
        obs_sym.delete();
        obs_done.delete();
        obs_stamp.delete();
        sym_since_rst = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(8'hA5, 1'b1);
        check_stream("a5_after_reset", 1'b1);

        // random frames of 1..3 words with random idle gaps between words
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                w = 8'($urandom);
                send_word(w, k == nw - 1);
            end
            check_stream("rand_frame", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
